alu_iter_exec: RTL and testbench
================================

# alu_iter_exec

Execution-side counterpart to the ALU control decoder: consumes the 4-bit `ALUCtrl` code plus two operands and produces the result. Add, sub, logic and compare complete in one cycle. Shifts run serially at one bit per cycle to save area and switching power. Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on multi-cycle shifts.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `SHAMT_W`, 5: shift-amount width, equal to clog2(`WIDTH`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: unit can accept this cycle.
- `alu_ctrl` in 4: operation code.
- `op_a` in `WIDTH`: operand A.
- `op_b` in `WIDTH`: operand B; shift amount is `op_b[SHAMT_W-1:0]`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `result` out `WIDTH`: registered result.
- `zero` out 1: `result == 0`, registered with `result`.
- `illegal` out 1: `alu_ctrl` was not a defined code.

## Operation
- Codes:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0101 SLT (signed)
  - 0110 SLTU
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA
  - All other codes: result 0, `illegal`=1, single-cycle.
- ADD/SUB wrap modulo 2^`WIDTH`. SLT/SLTU give 1 or 0 zero-extended to `WIDTH`.
- Accept happens when `in_valid && in_ready`. `op_a`, `op_b` and `alu_ctrl` are captured only on accept; operand registers do not toggle otherwise.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- FSM states IDLE, SHIFT:
  - IDLE, accept of a non-shift op or a shift with shamt 0: result registered, `out_valid`=1 next cycle, stay IDLE.
  - IDLE, accept of a shift with shamt ≥ 1: load working register with `op_a`, load counter with shamt, go to SHIFT.
  - SHIFT: each cycle shift one position and decrement the counter.
    - SLL fills with 0. SRL fills with 0. SRA fills with the sign bit, replicated every step.
    - When the counter reaches 1, the final step writes `result`/`zero`, sets `out_valid`, and returns to IDLE.
- Output hold: `out_valid`, `result`, `zero` and `illegal` stay stable until `out_ready`=1.
- Simultaneous consume and accept in IDLE: the old result leaves and the new one is registered in the same edge, so `out_valid` stays 1.
- Consume with no accept: `out_valid` goes to 0 next cycle.
- `alu_ctrl`, `op_a` and `op_b` changing while not accepted have no effect.
- Reset, including mid-SHIFT, clears state, counter and working register. Any in-flight operation is dropped.

## Timing
- Reset values:
  - `out_valid`=0
  - `result`=0
  - `zero`=0
  - `illegal`=0
  - state IDLE
  - `in_ready`=1 once `rst_n` is high.
- Latency from accept edge T to `out_valid`:
  - Non-shift, or shamt 0: T+1.
  - Shift: T+shamt. Maximum T+31 at `WIDTH`=32.
- Throughput: 1 op/cycle for non-shift ops while `out_ready`=1. `in_ready`=0 throughout SHIFT.
- `in_ready` is combinational from `state`, `out_valid` and `out_ready`. No combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `alu_pkg`:
  - `ALUCtrl` code constants (the same values the decoder emits).
  - FSM state enum.
  - `WIDTH` default.
- Sub-module `alu_serial_shifter`:
  - Inputs: load, operand, shamt, direction/arith.
  - Outputs: done, data.
  - Owns the counter and working register.
- Top level holds the handshake, single-cycle datapath and output registers.

## Test plan
- Reset with `out_valid` asserted and mid-SHIFT (SLL, shamt 20) -> all outputs 0 immediately, `in_ready`=1 after release, no stale result.
- Back-to-back ops with `out_ready`=1:
  - ADD 0xFFFFFFFF+1 -> 0, `zero`=1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - AND 0xF0F0,0xFF00 -> 0xF000.
  - All complete on consecutive cycles.
- SLT 0x80000000,1 -> 1. SLTU 0x80000000,1 -> 0. Code 1111 -> 0 with `illegal`=1.
- Shifts:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF, `out_valid` exactly 31 cycles after accept.
  - SRL same operands -> 1.
  - SLL 1 by 0 -> 1, valid at T+1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result -> `result` stable, `in_ready`=0, new `in_valid` not accepted. Release with `in_valid`=1 -> consume and accept on the same edge.
- Random ops against a reference model with random `in_valid`/`out_ready` -> results match in order, and operands never change while not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl code points, FSM states, default width.
// Imported by the EX-stage ALU and its serial shifter.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

endpackage

// File: rtl/alu_iter_exec_shifter.sv
// One-bit-per-cycle shifter: owns the working register and step counter.
// Ports: i_load/i_operand/i_shamt/i_left/i_arith in, o_done/o_data out.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_left,
  input  logic               i_arith,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_data
);

  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_arith;
  logic [WIDTH-1:0]   w_step;
  logic               w_fill;

  // Sign bit is re-read every step so SRA keeps replicating it.
  assign w_fill = r_arith & r_work[WIDTH-1];
  assign w_step = r_left ? {r_work[WIDTH-2:0], 1'b0}
                         : {w_fill, r_work[WIDTH-1:1]};

  // o_data is the value after the step taken on this edge.
  assign o_data = w_step;
  assign o_done = (r_cnt == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_load) begin
      r_work  <= i_operand;
      r_cnt   <= i_shamt;
      r_left  <= i_left;
      r_arith <= i_arith;
    end else if (r_cnt != '0) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// EX-stage ALU: single-cycle arith/logic/compare, serial shifts, valid/ready.
// Ports: in_valid/in_ready/alu_ctrl/op_a/op_b in, out_valid/result/zero/illegal out.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic               w_acc;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_start;
  logic [WIDTH-1:0]   w_alu;
  logic               w_ill;
  logic               w_done;
  logic [WIDTH-1:0]   w_sh_data;

  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_shamt  = op_b[SHAMT_W-1:0];
  assign w_is_shift = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) ||
                      (alu_ctrl == ALU_SRA);
  assign w_start  = w_acc && w_is_shift && (w_shamt != '0);

  // Shifts by zero fall through here and return op_a unchanged.
  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    unique case (alu_ctrl)
      ALU_ADD:  w_alu = op_a + op_b;
      ALU_SUB:  w_alu = op_a - op_b;
      ALU_AND:  w_alu = op_a & op_b;
      ALU_OR:   w_alu = op_a | op_b;
      ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, op_a < op_b};
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu = op_a;
      default:  w_ill = 1'b1;
    endcase
  end

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_start),
    .i_operand (op_a),
    .i_shamt   (w_shamt),
    .i_left    (alu_ctrl == ALU_SLL),
    .i_arith   (alu_ctrl == ALU_SRA),
    .o_done    (w_done),
    .o_data    (w_sh_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_done)  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_sh_data;
        r_zero      <= (w_sh_data == '0);
        r_illegal   <= 1'b0;
      end
    end else if (w_start) begin
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu;
      r_zero      <= (w_alu == '0);
      r_illegal   <= w_ill;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: directed scenarios plus randomized traffic
// checked against a behavioural ALU model with a latency countdown.
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  bit          m_valid;
  logic [31:0] m_res;
  bit          m_ill;
  int          busy;
  logic [31:0] sh_res;

  always #5 clk = ~clk;

  alu_iter_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  function automatic void ref_alu(input logic [3:0] c,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r,
                                  output bit il);
    int unsigned sh;
    sh = b % 32;
    r  = 0;
    il = 0;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: r = $signed(a) >>> sh;
      default: il = 1;
    endcase
  endfunction

  function automatic bit is_shift(input logic [3:0] c);
    return (c == 4'd7) || (c == 4'd8) || (c == 4'd9);
  endfunction

  task automatic model_clear();
    m_valid = 0;
    m_res   = 0;
    m_ill   = 0;
    busy    = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
    in_valid  = v;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    #1;
  endtask

  // Updates the model for the coming edge, then moves to the next negedge.
  task automatic advance();
    bit          rdy;
    logic [31:0] r;
    bit          il;
    int          sh;
    rdy = (busy == 0) && (!m_valid || out_ready);
    if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        m_valid = 1;
        m_res   = sh_res;
        m_ill   = 0;
      end
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (in_valid && rdy) begin
        ref_alu(alu_ctrl, op_a, op_b, r, il);
        sh = int'(op_b[4:0]);
        if (is_shift(alu_ctrl) && sh != 0) begin
          busy   = sh;
          sh_res = r;
        end else begin
          m_valid = 1;
          m_res   = r;
          m_ill   = il;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit stale;
    rst_n = 1'b0;
    drive(0, 4'd0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if ({out_valid, zero, illegal, result} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b z=%b i=%b r=%h want all 0",
               out_valid, zero, illegal, result);
    end
    rst_n = 1'b1;
    model_clear();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    drive(1, 4'd0, 32'd3, 32'd4, 0);
    advance();
    drive(0, 4'd0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd7) begin
      failures++;
      $display("FAIL pre_reset_valid: got v=%b r=%h want 1/7", out_valid, result);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, zero, illegal, result} !== 35'd0) begin
      failures++;
      $display("FAIL reset_with_valid: got v=%b r=%h want 0/0", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive(1, 4'd7, 32'd1, 32'd20, 1);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'd0, 0, 0, 1);
      advance();
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_shift_ready: got %b want 0", in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, zero, illegal, result} !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_shift: got v=%b r=%h want 0/0", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive(0, 4'd0, 0, 0, 1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) stale = 1;
      advance();
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL stale_shift_result: got out_valid=1 want 0 after reset");
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1);
    advance();
    drive(1, 4'd1, 32'd5, 32'd7, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'd0 || zero !== 1) begin
      failures++;
      $display("FAIL add_wrap: got v=%b r=%h z=%b want 1/0/1", out_valid, result, zero);
    end
    advance();
    drive(1, 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'hFFFF_FFFE || zero !== 0) begin
      failures++;
      $display("FAIL sub: got v=%b r=%h z=%b want 1/fffffffe/0", out_valid, result, zero);
    end
    advance();
    drive(1, 4'd5, 32'h8000_0000, 32'd1, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'h0000_F000) begin
      failures++;
      $display("FAIL and: got v=%b r=%h want 1/f000", out_valid, result);
    end
    advance();
    drive(1, 4'd6, 32'h8000_0000, 32'd1, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'd1) begin
      failures++;
      $display("FAIL slt: got v=%b r=%h want 1/1", out_valid, result);
    end
    advance();
    drive(1, 4'hF, 32'h1234, 32'h5678, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'd0 || zero !== 1) begin
      failures++;
      $display("FAIL sltu: got v=%b r=%h z=%b want 1/0/1", out_valid, result, zero);
    end
    advance();
    drive(0, 4'd0, 0, 0, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'd0 || illegal !== 1) begin
      failures++;
      $display("FAIL illegal: got v=%b r=%h i=%b want 1/0/1", out_valid, result, illegal);
    end
    advance();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic run_shift(input string nm, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [31:0] want);
    int  n;
    bit  rdy_bad;
    drive(1, c, a, b, 1);
    advance();
    n = 0;
    rdy_bad = 0;
    drive(0, 4'd0, 0, 0, 1);
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready !== 1'b0) rdy_bad = 1;
      advance();
      n++;
    end
    checks++;
    if (n !== lat || rdy_bad) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges (ready_bad=%0b) want %0d",
               nm, n, rdy_bad, lat);
    end
    checks++;
    if (result !== want || zero !== (want == 0) || illegal !== 0) begin
      failures++;
      $display("FAIL %s_result: got %h z=%b want %h", nm, result, zero, want);
    end
    advance();
  endtask

  task automatic test_shift();
    run_shift("sra31", 4'd9, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF);
    run_shift("srl31", 4'd8, 32'h8000_0000, 32'd31, 31, 32'h0000_0001);
    run_shift("sll0",  4'd7, 32'h0000_0001, 32'd0,  0,  32'h0000_0001);
    run_shift("sll5",  4'd7, 32'h0000_0003, 32'hFFFF_FFE5, 5, 32'h0000_0060);
  endtask

  task automatic test_backpressure();
    bit bad;
    drive(1, 4'd0, 32'd3, 32'd4, 1);
    advance();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd3, 32'hA, 32'h5, 0);
      if (out_valid !== 1 || result !== 32'd7 || in_ready !== 0) bad = 1;
      advance();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold: got v=%b r=%h rdy=%b want 1/7/0", out_valid, result, in_ready);
    end
    drive(1, 4'd3, 32'hA, 32'h5, 1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    advance();
    drive(0, 4'd0, 0, 0, 1);
    checks++;
    if (out_valid !== 1 || result !== 32'hF) begin
      failures++;
      $display("FAIL consume_accept: got v=%b r=%h want 1/f", out_valid, result);
    end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int i = 0; i < 600; i++) begin
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b = b & 32'h7;
      drive(($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
            $urandom, b, ($urandom_range(0, 9) < 7));
      checks++;
      if (in_ready !== ((busy == 0) && (!m_valid || out_ready))) begin
        failures++;
        $display("FAIL rnd_ready @%0d: got %b busy=%0d mv=%0b", i, in_ready, busy, m_valid);
      end
      checks++;
      if (out_valid !== m_valid) begin
        failures++;
        $display("FAIL rnd_valid @%0d: got %b want %b", i, out_valid, m_valid);
      end else if (m_valid) begin
        checks++;
        if (result !== m_res || zero !== (m_res == 0) || illegal !== m_ill) begin
          failures++;
          $display("FAIL rnd_result @%0d: got %h z=%b i=%b want %h i=%b",
                   i, result, zero, illegal, m_res, m_ill);
        end
      end
      advance();
    end
  endtask

  initial begin
    model_clear();
    drive(0, 4'd0, 0, 0, 1);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_shift();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
